// File: rtl/bram4_pkg.sv
// Shared definitions for the four-bank BRAM read/write paths: state encoding,
// control/status register bit positions and bank count.
package bram4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_CLAMP   = 2;
  localparam int STAT_CNT_LSB = 16;

  localparam int NUM_BANKS    = 4;

endpackage

// File: rtl/bram4_bank_mapper.sv
// Registered mapper from a linear word index to a one-hot bank strobe and a
// shared per-bank address (word i -> bank i mod 4, address i/4).
module bram4_bank_mapper
  import bram4_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [ADDR_W+1:0]    idx_i,
  output logic                 en_o,
  output logic [NUM_BANKS-1:0] we_o,
  output logic [ADDR_W-1:0]    addr_o
);

  logic                 en_q;
  logic [NUM_BANKS-1:0] we_q;
  logic [ADDR_W-1:0]    addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      we_q   <= '0;
      addr_q <= '0;
    end else begin
      en_q <= en_i;
      we_q <= en_i ? (NUM_BANKS'(1) << idx_i[1:0]) : '0;
      if (en_i) addr_q <= idx_i[ADDR_W+1:2];
    end
  end

  assign en_o   = en_q;
  assign we_o   = we_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/bram4_stream_writer.sv
// Fills four interleaved BRAM banks from a valid/ready stream, started and
// monitored through the shared control/status register pair.
module bram4_stream_writer
  import bram4_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = ADDR_W + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          control_signal,
  input  logic [CNT_W-1:0]     length,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 bram_en,
  output logic [NUM_BANKS-1:0] bram_we,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic [DATA_W-1:0]    bram_din,
  output logic [31:0]          status_signal
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(NUM_BANKS) << ADDR_W;

  function automatic logic [15:0] sat16(input logic [CNT_W-1:0] v);
    logic [CNT_W+15:0] wide;
    wide = {16'b0, v};
    return (|wide[CNT_W+15:16]) ? 16'hFFFF : wide[15:0];
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               clamp_q, clamp_d;
  logic               start_prev_q;
  logic [DATA_W-1:0]  din_q;
  logic               start_edge, abort, accept;
  logic               unused_ctrl;

  assign unused_ctrl = ^control_signal[31:2];
  assign start_edge  = control_signal[CTRL_START] & ~start_prev_q;
  assign abort       = control_signal[CTRL_ABORT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    clamp_d = clamp_q;
    accept  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            clamp_d = (length > CAP);
            len_d   = clamp_d ? CAP : length;
            cnt_d   = '0;
            state_d = (len_d == '0) ? ST_DONE : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (s_valid) begin
            accept = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == len_q - CNT_W'(1)) state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // start_prev resets high so a start bit held through reset is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      clamp_q      <= 1'b0;
      start_prev_q <= 1'b1;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      clamp_q      <= clamp_d;
      start_prev_q <= control_signal[CTRL_START];
      if (accept) din_q <= s_data;
    end
  end

  bram4_bank_mapper #(
    .ADDR_W (ADDR_W)
  ) u_mapper (
    .clk    (clk),
    .rst    (rst),
    .en_i   (accept),
    .idx_i  (cnt_q[ADDR_W+1:0]),
    .en_o   (bram_en),
    .we_o   (bram_we),
    .addr_o (bram_addr)
  );

  assign bram_din = din_q;
  assign s_ready  = (state_q == ST_WRITE);

  always_comb begin
    status_signal                           = '0;
    status_signal[STAT_BUSY]                = (state_q == ST_WRITE) || (state_q == ST_FLUSH);
    status_signal[STAT_DONE]                = (state_q == ST_DONE);
    status_signal[STAT_CLAMP]               = clamp_q;
    status_signal[STAT_CNT_LSB+15:STAT_CNT_LSB] = sat16(cnt_q);
  end

endmodule

// File: tb/tb_bram4_stream_writer.sv
// Directed bench for bram4_stream_writer with a write-strobe scoreboard.
module tb_bram4_stream_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl;
  logic [12:0] length;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_din;
  logic [31:0] status;

  typedef struct {
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] din;
  } exp_t;

  exp_t        sb[$];
  int          n_chk    = 0;
  int          n_fail   = 0;
  int          n_strobe = 0;
  int          bidx     = 0;
  logic [3:0]  last_we  = '0;
  logic [9:0]  last_addr = '0;

  always #5 clk = ~clk;

  bram4_stream_writer dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (ctrl),
    .length         (length),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .bram_en        (bram_en),
    .bram_we        (bram_we),
    .bram_addr      (bram_addr),
    .bram_din       (bram_din),
    .status_signal  (status)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest accepted beat.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && bram_en) begin
      n_strobe++;
      check("strobe_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_we", 64'(bram_we), 64'(e.we));
        check("strobe_addr", 64'(bram_addr), 64'(e.addr));
        check("strobe_din", 64'(bram_din), 64'(e.din));
        last_we   = bram_we;
        last_addr = bram_addr;
      end
    end
  end

  task automatic start(input int len);
    length  = 13'(len);
    ctrl[0] = 1'b1;
    @(negedge clk);
    ctrl[0] = 1'b0;
    bidx    = 0;
  endtask

  task automatic stream(input int n, input bit bubbles, input logic [31:0] base);
    int sent = 0;
    int cyc  = 0;
    bit ph   = 1'b0;
    exp_t e;
    while (sent < n && cyc < 20000) begin
      s_valid = bubbles ? ph : 1'b1;
      ph      = ~ph;
      s_data  = base + 32'(sent);
      if (s_valid && s_ready) begin
        e.we   = 4'(1) << bidx[1:0];
        e.addr = 10'(bidx >> 2);
        e.din  = s_data;
        sb.push_back(e);
        bidx++;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    check("stream_accepts", 64'(sent), 64'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(s_ready), 64'(0));
    check({tag, "_en"}, 64'(bram_en), 64'(0));
    check({tag, "_we"}, 64'(bram_we), 64'(0));
    check({tag, "_addr"}, 64'(bram_addr), 64'(0));
    check({tag, "_din"}, 64'(bram_din), 64'(0));
    check({tag, "_status"}, 64'(status), 64'(0));
  endtask

  initial begin
    int s0;
    rst     = 1'b1;
    ctrl    = '0;
    length  = '0;
    s_data  = '0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Basic fill
    s0 = n_strobe;
    start(8);
    check("basic_ready_after_start", 64'(s_ready), 64'(1));
    check("basic_busy", 64'(status[2:0]), 64'(3'b001));
    stream(8, 1'b0, 32'h100);
    check("basic_flush_ready", 64'(s_ready), 64'(0));
    check("basic_flush_status", 64'(status[1:0]), 64'(2'b01));
    @(negedge clk);
    check("basic_done_status", 64'(status[2:0]), 64'(3'b010));
    check("basic_count", 64'(status[31:16]), 64'(8));
    check("basic_strobes", 64'(n_strobe - s0), 64'(8));

    // Bubbles
    s0 = n_strobe;
    start(5);
    stream(5, 1'b1, 32'hA00);
    repeat (2) @(negedge clk);
    check("bubble_strobes", 64'(n_strobe - s0), 64'(5));
    check("bubble_done", 64'(status[1]), 64'(1));
    check("bubble_count", 64'(status[31:16]), 64'(5));

    // Zero length
    s0 = n_strobe;
    start(0);
    check("zero_done", 64'(status[2:0]), 64'(3'b010));
    check("zero_ready", 64'(s_ready), 64'(0));
    repeat (3) @(negedge clk);
    check("zero_ready_later", 64'(s_ready), 64'(0));
    check("zero_strobes", 64'(n_strobe - s0), 64'(0));

    // Clamp
    s0 = n_strobe;
    start(5000);
    check("clamp_flag", 64'(status[2]), 64'(1));
    stream(4096, 1'b0, 32'h10000);
    @(negedge clk);
    check("clamp_last_we", 64'(last_we), 64'(4'b1000));
    check("clamp_last_addr", 64'(last_addr), 64'(1023));
    check("clamp_done", 64'(status[2:0]), 64'(3'b110));
    check("clamp_strobes", 64'(n_strobe - s0), 64'(4096));
    check("clamp_count", 64'(status[31:16]), 64'(4096));

    // Abort after six accepts
    s0 = n_strobe;
    start(16);
    check("abort_clamp_cleared", 64'(status[2]), 64'(0));
    stream(6, 1'b0, 32'h200);
    ctrl[1] = 1'b1;
    @(negedge clk);
    ctrl[1] = 1'b0;
    check("abort_idle_ready", 64'(s_ready), 64'(0));
    check("abort_idle_en", 64'(bram_en), 64'(0));
    check("abort_status", 64'(status), 64'({16'd6, 16'd0}));
    check("abort_strobes", 64'(n_strobe - s0), 64'(6));
    repeat (2) @(negedge clk);
    check("abort_stays_idle", 64'(status[1:0]), 64'(0));
    start(4);
    stream(4, 1'b0, 32'h300);
    repeat (2) @(negedge clk);
    check("restart_done", 64'(status[1]), 64'(1));
    check("restart_count", 64'(status[31:16]), 64'(4));

    // Reset mid-write with start held high
    start(16);
    stream(3, 1'b0, 32'h400);
    rst     = 1'b1;
    ctrl[0] = 1'b1;
    #1;
    check_all_zero("midrst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("midrst_held_start");
    ctrl[0] = 1'b0;
    @(negedge clk);
    s0 = n_strobe;
    start(2);
    check("midrst_restart_ready", 64'(s_ready), 64'(1));
    stream(2, 1'b0, 32'h500);
    repeat (2) @(negedge clk);
    check("midrst_restart_done", 64'(status[1]), 64'(1));
    check("midrst_restart_strobes", 64'(n_strobe - s0), 64'(2));

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram4_stream_writer.md
# bram4_stream_writer

Fills four BRAM banks from a valid/ready word stream, interleaving consecutive words across the banks: word i goes to bank i mod 4 at address i/4. It is the write-side counterpart of the 4-BRAM read path and uses the same `control_signal`/`status_signal` register pair for start and completion. It sits between the ingest stream and the BRAM write ports, so the reader later sees four parallel banks holding the data in order.

## Interface
- `ADDR_W`, 10, per-bank address width; bank depth = 2**ADDR_W
- `DATA_W`, 32, word width
- `CNT_W`, ADDR_W+3, width of the length field; holds 0..4*2**ADDR_W
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `control_signal`  in  32  bit0 start (rising edge sensed), bit1 abort (level), others ignored
- `length`  in  CNT_W  number of words to write; sampled on the start edge
- `s_data`  in  DATA_W  stream word
- `s_valid`  in  1  stream word present
- `s_ready`  out  1  block accepts word this cycle
- `bram_en`  out  1  write strobe common to all banks
- `bram_we`  out  4  one-hot bank select
- `bram_addr`  out  ADDR_W  shared bank address
- `bram_din`  out  DATA_W  shared write data
- `status_signal`  out  32  bit0 busy, bit1 done, bit2 length_clamped, [31:16] words written (saturating low 16 bits of the count); others 0

## Operation
- States: IDLE, WRITE, FLUSH, DONE.
- **IDLE**
  - On a start rising edge (`control_signal[0]` is 1 now and was 0 last cycle), latch `length`.
  - Clear the count, clear done, go to WRITE.
  - If the latched length is 0, go directly to DONE.
- **Clamping**
  - A length above 4*2**ADDR_W is clamped to 4*2**ADDR_W.
  - When this happens, set `length_clamped`; it stays set until the next start.
- **WRITE**
  - `s_ready` = 1.
  - A beat is accepted when `s_valid && s_ready`.
  - On an accepted beat with index i: register `bram_din` = `s_data`, `bram_addr` = i[ADDR_W+1:2], `bram_we` = 1 << i[1:0], `bram_en` = 1; then increment i.
  - When the accepted beat is the last one (i == length−1), go to FLUSH.
- **FLUSH**: one cycle, so the final write strobe completes before done is reported; then go to DONE.
- **DONE**
  - done = 1, busy = 0.
  - Stay until the next start edge, which behaves exactly as a start in IDLE.
- **Abort**
  - `control_signal[1]` = 1 in any state sends the FSM to IDLE next cycle, with `bram_en` = 0 on that cycle.
  - done is not set. The count and clamp bits hold their values for inspection.
- A start edge in WRITE or FLUSH is ignored.
- If abort and a start edge occur in the same cycle, abort wins.
- busy = 1 in WRITE and FLUSH.

## Timing
- Every output is 0 while `rst` is high and immediately after it deasserts.
- Beat accepted in cycle t → `bram_en`/`bram_we`/`bram_addr`/`bram_din` valid in cycle t+1, each for exactly one cycle.
- Back-to-back beats give back-to-back strobes.
- `s_ready` is a registered state decode; it is never combinationally dependent on `s_valid`.
- Last beat accepted at cycle t:
  - t+1: final write strobe, state FLUSH, `s_ready` = 0.
  - t+2: done = 1.
- Start edge at cycle t → WRITE and `s_ready` = 1 at t+1.
- Count arithmetic is unsigned CNT_W bits and never wraps, because a clamped length is ≤ capacity.
- At the full length, the last word lands in bank 3 at address 2**ADDR_W−1.

## Structure
- Shared package `bram4_pkg` holds:
  - the state encoding (IDLE=0, WRITE=1, FLUSH=2, DONE=3);
  - control bit indices (START=0, ABORT=1);
  - status bit indices (BUSY=0, DONE=1, CLAMP=2, CNT_LSB=16);
  - `NUM_BANKS`=4.
- One natural sub-module is `bram4_bank_mapper`, a registered index-to-(bank one-hot, address) mapper reused by the reader.
- The rest is a single FSM plus counter.

## Test plan
- **Basic fill**: ADDR_W=10, length=8, words 0x100..0x107 with `s_valid` held high.
  - Strobes go to banks 0,1,2,3,0,1,2,3 at addresses 0,0,0,0,1,1,1,1.
  - done rises 2 cycles after the 8th accept; `status_signal[31:16]` = 8.
- **Bubbles**: length=5 with `s_valid` toggled every other cycle.
  - Exactly 5 strobes; no strobe occurs on idle cycles; data order is preserved.
- **Zero length**: start edge with length=0.
  - DONE on the next cycle, no `bram_en` pulse, `s_ready` never asserted.
- **Clamp**: length=5000 (capacity 4096), stream 4096 words.
  - `length_clamped` = 1; last strobe is `bram_we`=4'b1000, `bram_addr`=1023; done is set.
- **Abort**: length=16, assert abort after the 6th accept.
  - At most 6 strobes; IDLE next cycle; done=0, count=6.
  - A fresh start then writes from bank 0, address 0.
- **Reset mid-write**: assert `rst` during WRITE.
  - All outputs go to 0 immediately.
  - After release the block stays in IDLE until a new start edge; holding `control_signal[0]` high through reset does not count as an edge.
